// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe datapath: board cell codes, players
// and the turn controller state machine.
package ttt_pkg;

    localparam int NUM_SQUARES = 9;

    localparam logic [1:0] POS_EMPTY = 2'b00;
    localparam logic [1:0] POS_P1    = 2'b01;
    localparam logic [1:0] POS_P2    = 2'b10;

    typedef enum logic {
        PLAYER_P1 = 1'b0,
        PLAYER_P2 = 1'b1
    } player_t;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/turn_controller_if.sv
// Player-input / board-readback / write-strobe bundle between the switch
// front end, turn_controller and position_tracker.
interface turn_controller_if;
    import ttt_pkg::*;

    logic [NUM_SQUARES-1:0] sel;
    logic                   confirm;
    logic [1:0]             pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8;
    logic                   game_over;
    logic [NUM_SQUARES-1:0] p1_en;
    logic [NUM_SQUARES-1:0] p2_en;
    logic                   move_check;
    logic                   turn;
    logic                   invalid;
    logic [3:0]             move_count;
    logic                   board_full;

    modport master (
        output sel, confirm, game_over,
        output pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8,
        input  p1_en, p2_en, move_check, turn, invalid, move_count, board_full
    );

    modport slave (
        input  sel, confirm, game_over,
        input  pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8,
        output p1_en, p2_en, move_check, turn, invalid, move_count, board_full
    );

endinterface

// File: rtl/move_validator.sv
// Combinational legality check of a square selection against the board.
// Cells coded 11 count as occupied.
module move_validator
    import ttt_pkg::*;
(
    input  logic [NUM_SQUARES-1:0] i_sel,
    input  logic [1:0]             i_pos0,
    input  logic [1:0]             i_pos1,
    input  logic [1:0]             i_pos2,
    input  logic [1:0]             i_pos3,
    input  logic [1:0]             i_pos4,
    input  logic [1:0]             i_pos5,
    input  logic [1:0]             i_pos6,
    input  logic [1:0]             i_pos7,
    input  logic [1:0]             i_pos8,
    output logic                   o_onehot_ok,
    output logic                   o_square_free
);

    logic [NUM_SQUARES-1:0] w_occupied;

    assign w_occupied = {i_pos8 != POS_EMPTY, i_pos7 != POS_EMPTY, i_pos6 != POS_EMPTY,
                         i_pos5 != POS_EMPTY, i_pos4 != POS_EMPTY, i_pos3 != POS_EMPTY,
                         i_pos2 != POS_EMPTY, i_pos1 != POS_EMPTY, i_pos0 != POS_EMPTY};

    // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot
    assign o_onehot_ok   = (i_sel != '0) && ((i_sel & (i_sel - 1'b1)) == '0);
    assign o_square_free = ((i_sel & w_occupied) == '0);

endmodule

// File: rtl/turn_controller.sv
// Turns a confirmed square selection into one-cycle p1_en/p2_en/move_check
// strobes for position_tracker, alternating players until the game ends.
module turn_controller
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0,
    parameter int MAX_MOVES    = 9
)(
    input  logic              clk,
    input  logic              reset,
    turn_controller_if.slave  bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_MOVES);

    state_t                 r_state;
    state_t                 w_next;
    logic [NUM_SQUARES-1:0] r_sel_q;
    logic                   r_turn;
    logic [3:0]             r_count;
    logic                   r_board_full;
    logic [NUM_SQUARES-1:0] r_p1_en;
    logic [NUM_SQUARES-1:0] r_p2_en;
    logic                   r_move_check;
    logic                   r_invalid;

    logic                   w_onehot_ok;
    logic                   w_square_free;
    logic                   w_load_sel;
    logic                   w_issue;
    logic                   w_reject;
    logic                   w_advance;
    logic [3:0]             w_count_inc;

    move_validator u_validator (
        .i_sel         (r_sel_q),
        .i_pos0        (bus.pos0),
        .i_pos1        (bus.pos1),
        .i_pos2        (bus.pos2),
        .i_pos3        (bus.pos3),
        .i_pos4        (bus.pos4),
        .i_pos5        (bus.pos5),
        .i_pos6        (bus.pos6),
        .i_pos7        (bus.pos7),
        .i_pos8        (bus.pos8),
        .o_onehot_ok   (w_onehot_ok),
        .o_square_free (w_square_free)
    );

    assign w_count_inc = r_count + 4'd1;

    always_comb begin
        w_next     = r_state;
        w_load_sel = 1'b0;
        w_issue    = 1'b0;
        w_reject   = 1'b0;
        w_advance  = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (bus.game_over) begin
                    w_next = ST_DONE;
                end else if (bus.confirm) begin
                    w_next     = ST_CHECK;
                    w_load_sel = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_onehot_ok && w_square_free) begin
                    w_next  = ST_ISSUE;
                    w_issue = 1'b1;
                end else begin
                    w_next   = ST_WAIT;
                    w_reject = 1'b1;
                end
            end
            ST_ISSUE: w_next = ST_SETTLE;
            ST_SETTLE: begin
                w_advance = 1'b1;
                w_next    = ((w_count_inc == MAX_CNT) || bus.game_over) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: w_next = ST_DONE;
            default: w_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_sel_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_sel) r_sel_q <= bus.sel;
        end
    end

    // Strobes are registered on the CHECK->ISSUE edge so they coincide with ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_en      <= '0;
            r_p2_en      <= '0;
            r_move_check <= 1'b0;
            r_invalid    <= 1'b0;
        end else begin
            r_p1_en      <= (w_issue && (r_turn == PLAYER_P1)) ? r_sel_q : '0;
            r_p2_en      <= (w_issue && (r_turn == PLAYER_P2)) ? r_sel_q : '0;
            r_move_check <= w_issue;
            r_invalid    <= w_reject;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_turn       <= FIRST_PLAYER;
            r_count      <= '0;
            r_board_full <= 1'b0;
        end else if (w_advance) begin
            r_turn       <= ~r_turn;
            r_count      <= w_count_inc;
            r_board_full <= (w_count_inc == MAX_CNT);
        end
    end

    assign bus.p1_en      = r_p1_en;
    assign bus.p2_en      = r_p2_en;
    assign bus.move_check = r_move_check;
    assign bus.invalid    = r_invalid;
    assign bus.turn       = r_turn;
    assign bus.move_count = r_count;
    assign bus.board_full = r_board_full;

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Upstream stage of position_tracker. Converts a player's square selection and confirm pulse into the one-hot p1_en/p2_en write strobes and the move_check strobe that position_tracker consumes. Validates each requested move against the current board read back from position_tracker (pos0..pos8). Alternates turns, counts moves, and stops accepting moves at game end.

Parameters:
FIRST_PLAYER, 0, player who moves after reset (0 = P1, 1 = P2)
MAX_MOVES, 9, move count at which the board is full and the FSM enters DONE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sel  input  9  square selection from switches; bit i = square i; must be one-hot
confirm  input  1  single-cycle, already-debounced "place move" pulse
pos0..pos8  input  2 each  board state from position_tracker; 00 empty, 01 P1, 10 P2, 11 illegal (treated as occupied)
game_over  input  1  win/draw indication from downstream judge; level-sensitive
p1_en  output  9  one-hot write strobe for P1, high for exactly one cycle per accepted move
p2_en  output  9  one-hot write strobe for P2, high for exactly one cycle per accepted move
move_check  output  1  strobe to position_tracker, high in the same cycle as a p1_en/p2_en strobe
turn  output  1  player to move (0 = P1, 1 = P2)
invalid  output  1  one-cycle pulse when a confirmed move is rejected
move_count  output  4  number of accepted moves, 0..9
board_full  output  1  high when move_count == MAX_MOVES

Behaviour:
- Reset (async, active-high), all outputs registered:
  - p1_en = 0, p2_en = 0, move_check = 0, invalid = 0, move_count = 0, board_full = 0
  - turn = FIRST_PLAYER, state = WAIT, sel_q = 0
- FSM states: WAIT, CHECK, ISSUE, SETTLE, DONE.
- WAIT:
  - game_over = 1 -> DONE (priority over confirm).
  - Otherwise, confirm = 1 at an edge -> latch sel into sel_q, go to CHECK.
- CHECK (one cycle). A move is valid iff both hold:
  - sel_q is exactly one-hot (not zero, not multiple bits).
  - The addressed pos is 00.
  - Valid -> ISSUE. Invalid -> invalid = 1 for the next cycle, return to WAIT; turn and move_count unchanged.
- ISSUE (one cycle):
  - p1_en = sel_q if turn = 0, else p2_en = sel_q; the other enable stays 0.
  - move_check = 1.
  - Next state is SETTLE.
- SETTLE (one cycle, lets position_tracker register the write). On exit:
  - turn toggles and move_count increments.
  - If the new move_count == MAX_MOVES, or game_over = 1 -> DONE; else -> WAIT.
- DONE: all strobes 0; confirm is ignored; stays in DONE until reset.
- Latency: confirm seen at edge N -> strobes high in cycle N+2 -> turn/move_count update at edge N+3 -> next confirm accepted from edge N+3.
- confirm is ignored in CHECK, ISSUE, SETTLE and DONE; it is not queued.
- sel changing after the confirm edge has no effect (sel_q is used).
- p1_en and p2_en are never nonzero in the same cycle; each carries at most one set bit.
- board_full = (move_count == MAX_MOVES), registered together with move_count.
- Reset asserted mid-ISSUE clears the strobes immediately (async); no partial move is counted.

Decomposition:
- Package ttt_pkg:
  - pos encoding constants (POS_EMPTY = 2'b00, POS_P1 = 2'b01, POS_P2 = 2'b10)
  - NUM_SQUARES = 9
  - FSM state enum
  - player encoding (P1 = 0, P2 = 1)
- One combinational sub-module, move_validator:
  - Inputs: sel_q and pos0..pos8.
  - Outputs: onehot_ok and square_free.
  - Reused later by the judge/AI stages.

Test Plan:
1. Reset, then sel = 9'b000000001 with confirm pulse, pos all 00 -> two cycles later p1_en = 9'b000000001 and move_check = 1 for exactly one cycle; then turn = 1, move_count = 1.
2. pos0 = 01, turn = 1, sel = 9'b000000001 with confirm -> invalid pulses one cycle; p2_en stays 0; turn = 1 and move_count = 1 unchanged.
3. sel = 9'b000000011 and sel = 0, each confirmed -> invalid pulse each time; no strobes.
4. Nine valid alternating moves (squares 0..8, board updated each SETTLE) -> strobes alternate p1/p2; final move_count = 9, board_full = 1, state DONE; a further confirm produces no strobe.
5. game_over raised after move 5 -> DONE; confirm ignored; move_count holds at 5.
6. Reset asserted during ISSUE -> p2_en/move_check drop asynchronously; after release turn = FIRST_PLAYER, move_count = 0.
